hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard detector for the 5-stage MIPS pipeline.
- Replaces pairwise RS/RT-vs-RT/RD compares with a per-register latency scoreboard, so one block covers load-use, ALU-to-branch, load-to-branch and multi-cycle multiplier hazards.
- Sits beside the ID stage and drives PC/IF_ID hold, the ID/EX bubble and the IF flush on taken branches.

Parameters:
- REGISTER_BITS, 5, register index width; entries 1..2^REGISTER_BITS-1 are tracked, r0 is never tracked.
- ALU_LAT, 1, scoreboard load value for ALU producers.
- LOAD_LAT, 2, scoreboard load value for loads.
- MUL_LAT, 4, scoreboard load value for multiplier results.
- CNT_W, 3, counter width; must satisfy max(ALU_LAT, LOAD_LAT, MUL_LAT) < 2^CNT_W.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REGISTER_BITS  source indices
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_is_branch  in  1  branch compared in ID
- id_reg_write  in  1  ID instruction writes id_rd
- id_rd  in  REGISTER_BITS  destination index
- id_class  in  2  producer class: 0 ALU, 1 LOAD, 2 MUL, 3 reserved (treated as ALU)
- branch_taken  in  1  ID branch resolved taken this cycle
- mem_stall  in  1  global freeze from memory system
- hold  out  1  hold PC and IF_ID
- id_flush  out  1  insert bubble into ID_EX
- if_flush  out  1  squash IF_ID
- stall_cause  out  2  registered: 0 none, 1 data, 2 branch-data, 3 mem

Behaviour:
- Scoreboard: cnt[r], r = 1..2^REGISTER_BITS-1, CNT_W bits each. All counters reset to 0.
- Per-source need: need(s) = id_valid & uses_s & (s != 0) & (cnt[s] > thr).
  - thr = 0 when id_is_branch (the compare happens in ID).
  - thr = 1 otherwise (the consumer reads in EX and is served by forwarding).
- data_haz = need(rs) | need(rt).
- hold = data_haz | mem_stall.
- id_flush = data_haz & ~mem_stall.
- if_flush = branch_taken & id_valid & ~data_haz & ~mem_stall. A branch that is itself stalled never flushes.
- Issue condition: id_valid & ~data_haz & ~mem_stall.
- On issue with id_reg_write and id_rd != 0, at the clock edge cnt[id_rd] <= LAT(id_class).
- Every other counter with cnt != 0 decrements by 1 per edge, unless mem_stall is high, in which case all counters hold.
- Issue and decrement on the same register in the same cycle: the issue value wins.
- Resulting latencies:
  - ALU to dependent ALU: 0 stalls.
  - ALU to branch: 1 stall.
  - LOAD to ALU: 1 stall.
  - LOAD to branch: 2 stalls.
  - MUL to ALU: MUL_LAT-1 stalls.
- Outputs are combinational from state and inputs, except stall_cause.
- stall_cause is updated each edge:
  - 3 if mem_stall;
  - else 2 if data_haz & id_is_branch;
  - else 1 if data_haz;
  - else 0.
- Reset (async assert, any time, including mid-stall): all cnt = 0, stall_cause = 0, and hold/id_flush/if_flush are forced to 0 while rst is high.
- Release: the first edge after rst deassertion is a normal cycle.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds outputs stall_cycles (32-bit) and flush_count (16-bit).
  - stall_cycles increments each cycle id_flush = 1.
  - flush_count increments each cycle if_flush = 1.
  - Both saturate at all-ones and clear on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- dev.v holds REGISTER_BITS, the id_class encodings (CLASS_ALU/LOAD/MUL) and the stall_cause encodings.
- One sub-module, hazard_reg_counter: a single CNT_W down-counter with load/enable/freeze, generated once per tracked register.

Test Plan:
- Load-use: lw r5 issues, next cycle add r6,r5,r1 in ID → hold = id_flush = 1 for exactly 1 cycle, stall_cause = 1; add issues on the following cycle.
- ALU to branch: add r3 issues, then beq r3,r4 with branch_taken = 1 → 1 stall cycle with if_flush = 0, then if_flush = 1 for exactly 1 cycle.
- Multiply, MUL_LAT = 4: mul r7 issues, then or r8,r7,r0 → id_flush high for 3 cycles; r0 and unused sources never stall.
- mem_stall = 1 for 5 cycles right after lw r5 issues → all counters frozen, hold = 1, id_flush = 0, stall_cause = 3; the dependent instruction still stalls 1 cycle after release.
- Back-to-back writes: lw r2 then add r2 issued the next cycle → cnt[r2] reloads to ALU_LAT; rst asserted mid-stall → outputs 0 immediately and no residual stall after release.
- With HAZARD_STATS_EN: run the first two scenarios → stall_cycles = 2, flush_count = 1.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared encodings for the ID-stage latency scoreboard
package hazard_scoreboard_pkg;

  localparam int DEF_REGISTER_BITS = 5;

  typedef enum logic [1:0] {
    CLASS_ALU  = 2'd0,
    CLASS_LOAD = 2'd1,
    CLASS_MUL  = 2'd2,
    CLASS_RSVD = 2'd3
  } id_class_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_DATA   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_MEM    = 2'd3
  } stall_cause_e;

endpackage

// File: rtl/hazard_reg_counter.sv
// rtl/hazard_reg_counter.sv - per-register result-latency down-counter with load and freeze
module hazard_reg_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt
);

  // A new producer overrides whatever was left of the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (!freeze && cnt != '0)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard driving hold, ID/EX bubble and IF flush
// Optional statistics outputs are enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REGISTER_BITS = DEF_REGISTER_BITS,
  parameter int ALU_LAT       = 1,
  parameter int LOAD_LAT      = 2,
  parameter int MUL_LAT       = 4,
  parameter int CNT_W         = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REGISTER_BITS-1:0] id_rs,
  input  logic [REGISTER_BITS-1:0] id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic                     id_is_branch,
  input  logic                     id_reg_write,
  input  logic [REGISTER_BITS-1:0] id_rd,
  input  logic [1:0]               id_class,
  input  logic                     branch_taken,
  input  logic                     mem_stall,
  output logic                     hold,
  output logic                     id_flush,
  output logic                     if_flush,
  output logic [1:0]               stall_cause
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [15:0]              flush_count
`endif
);

  localparam int NREG = 1 << REGISTER_BITS;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]           lat;
  logic [CNT_W-1:0]           thr;
  logic                       need_rs, need_rt, data_haz, issue, load_en;
  stall_cause_e               cause_q;

  always_comb begin
    lat = CNT_W'(ALU_LAT);
    case (id_class_e'(id_class))
      CLASS_LOAD: lat = CNT_W'(LOAD_LAT);
      CLASS_MUL:  lat = CNT_W'(MUL_LAT);
      default:    lat = CNT_W'(ALU_LAT);
    endcase
  end

  // r0 is hardwired to zero and never produces a hazard.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    hazard_reg_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load_en && (id_rd == REGISTER_BITS'(r))),
      .load_val (lat),
      .freeze   (mem_stall),
      .cnt      (cnt[r])
    );
  end

  // Branches compare in ID and cannot use EX forwarding, so they wait one cycle longer.
  assign thr      = id_is_branch ? '0 : CNT_W'(1);
  assign need_rs  = id_valid && id_uses_rs && (id_rs != '0) && (cnt[id_rs] > thr);
  assign need_rt  = id_valid && id_uses_rt && (id_rt != '0) && (cnt[id_rt] > thr);
  assign data_haz = need_rs || need_rt;
  assign issue    = id_valid && !data_haz && !mem_stall;
  assign load_en  = issue && id_reg_write && (id_rd != '0);

  assign hold     = !rst && (data_haz || mem_stall);
  assign id_flush = !rst && data_haz && !mem_stall;
  assign if_flush = !rst && branch_taken && issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cause_q <= CAUSE_NONE;
    else if (mem_stall)
      cause_q <= CAUSE_MEM;
    else if (data_haz && id_is_branch)
      cause_q <= CAUSE_BRANCH;
    else if (data_haz)
      cause_q <= CAUSE_DATA;
    else
      cause_q <= CAUSE_NONE;
  end

  assign stall_cause = cause_q;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (id_flush && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (if_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_is_branch, id_reg_write;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] id_class;
  logic       branch_taken, mem_stall;
  logic       hold, id_flush, if_flush;
  logic [1:0] stall_cause;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int pass_cnt = 0;
  int total    = 0;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .id_reg_write (id_reg_write),
    .id_rd        (id_rd),
    .id_class     (id_class),
    .branch_taken (branch_taken),
    .mem_stall    (mem_stall),
    .hold         (hold),
    .id_flush     (id_flush),
    .if_flush     (if_flush),
    .stall_cause  (stall_cause)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v, rs, rt, uses_rs, uses_rt, branch, reg_write, rd, class, taken
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic br, input logic rw,
                        input logic [4:0] rd, input logic [1:0] cls, input logic tk);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_reg_write = rw; id_rd = rd; id_class = cls; branch_taken = tk;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    mem_stall = 1'b1;
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_hold_forced", hold, 0);
    chk("rst_id_flush", id_flush, 0);
    chk("rst_cause", stall_cause, 0);
    mem_stall = 1'b0;
    rst = 1'b0;
    idle(1);
    chk("post_rst_cause", stall_cause, 0);

    // load-use: lw r5 ; add r6,r5,r1
    set_id(1, 0, 0, 0, 0, 0, 1, 5, 1, 0);
    chk("lw_issue_hold", hold, 0);
    tick();
    set_id(1, 5, 1, 1, 1, 0, 1, 6, 0, 0);
    chk("lu_hold", hold, 1);
    chk("lu_id_flush", id_flush, 1);
    chk("lu_if_flush", if_flush, 0);
    tick();
    chk("lu_cause", stall_cause, 1);
    chk("lu_release_hold", hold, 0);
    chk("lu_release_flush", id_flush, 0);
    tick();
    chk("lu_cause_clear", stall_cause, 0);
    idle(5);

    // ALU to branch: add r3 ; beq r3,r4 taken
    set_id(1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    set_id(1, 3, 4, 1, 1, 1, 0, 0, 0, 1);
    chk("ab_hold", hold, 1);
    chk("ab_id_flush", id_flush, 1);
    chk("ab_if_flush_stalled", if_flush, 0);
    tick();
    chk("ab_cause", stall_cause, 2);
    chk("ab_hold_release", hold, 0);
    chk("ab_if_flush", if_flush, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ab_if_flush_once", if_flush, 0);
`ifdef HAZARD_STATS_EN
    chk("stats_stall_cycles", stall_cycles, 2);
    chk("stats_flush_count", flush_count, 1);
`endif
    idle(5);

    // multiplier: mul r7 ; or r8,r7,r0
    set_id(1, 0, 0, 0, 0, 0, 1, 7, 2, 0);
    tick();
    set_id(1, 7, 0, 1, 1, 0, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mul_stall", id_flush, 1);
      tick();
    end
    chk("mul_release_flush", id_flush, 0);
    chk("mul_release_hold", hold, 0);
    tick();
    // mul writing r0 is never tracked
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 2, 0);
    tick();
    set_id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("r0_no_stall", hold, 0);
    tick();
    // unused source never stalls
    set_id(1, 0, 0, 0, 0, 0, 1, 9, 2, 0);
    tick();
    set_id(1, 9, 9, 0, 0, 1, 0, 0, 0, 0);
    chk("unused_src_no_stall", hold, 0);
    idle(6);

    // mem_stall freeze right after lw r5
    set_id(1, 0, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 1, 1, 0, 1, 6, 0, 0);
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("ms_hold", hold, 1);
      chk("ms_id_flush", id_flush, 0);
      tick();
      chk("ms_cause", stall_cause, 3);
    end
    mem_stall = 1'b0;
    #1;
    chk("ms_after_hold", hold, 1);
    chk("ms_after_flush", id_flush, 1);
    tick();
    chk("ms_after_cause", stall_cause, 1);
    chk("ms_after_issue", hold, 0);
    idle(5);

    // lw r2 then add r2: reload to ALU_LAT
    set_id(1, 0, 0, 0, 0, 0, 1, 2, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    chk("b2b_add_issue", hold, 0);
    tick();
    set_id(1, 2, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("b2b_branch_stall", hold, 1);
    idle(5);

    // mul r2 then add r2: reload must beat decrement (4 -> 1, not 3)
    set_id(1, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    tick();
    set_id(1, 2, 0, 1, 0, 0, 1, 10, 0, 0);
    chk("reload_wins", hold, 0);
    idle(5);

    // reset asserted mid-stall
    set_id(1, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    tick();
    set_id(1, 2, 0, 1, 0, 0, 1, 11, 0, 0);
    tick();
    chk("pre_rst_hold", hold, 1);
    chk("pre_rst_cause", stall_cause, 1);
    rst = 1'b1;
    #1;
    chk("midrst_hold", hold, 0);
    chk("midrst_id_flush", id_flush, 0);
    chk("midrst_cause", stall_cause, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_no_residual", hold, 0);
    tick();
    chk("post_rst_cause_zero", stall_cause, 0);
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
